// File: rtl/axis_adc_decim_2ch.sv
// Two-channel ADC decimator: each output is the sum of N accepted sample pairs.
// Optional overrun counter port sts_ovr_count is enabled by defining ADC_DECIM_OVR_COUNT_EN.
module axis_adc_decim_2ch #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CNTR_WIDTH       = 16
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic                          cfg_en,
    input  logic [CNTR_WIDTH-1:0]         cfg_data,
    input  logic                          s0_axis_tvalid,
    input  logic [AXIS_TDATA_WIDTH-1:0]   s0_axis_tdata,
    input  logic                          s1_axis_tvalid,
    input  logic [AXIS_TDATA_WIDTH-1:0]   s1_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [2*AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                          sts_overrun
`ifdef ADC_DECIM_OVR_COUNT_EN
    ,
    output logic [15:0]                   sts_ovr_count
`endif
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    logic                         state_q, state_d;
    logic [CNTR_WIDTH-1:0]        cnt_q, cnt_d;
    logic [CNTR_WIDTH-1:0]        n_q, n_d;
    logic signed [31:0]           acc_a_q, acc_a_d;
    logic signed [31:0]           acc_b_q, acc_b_d;
    logic signed [31:0]           res_a_q, res_a_d;
    logic signed [31:0]           res_b_q, res_b_d;
    logic                         tvalid_q, tvalid_d;
    logic                         ovr_q, ovr_d;

    logic                         accept;
    logic                         last;
    logic                         drop;
    logic [CNTR_WIDTH-1:0]        cnt_cur;
    logic [CNTR_WIDTH-1:0]        n_cur;
    logic [CNTR_WIDTH-1:0]        n_eff;
    logic [CNTR_WIDTH:0]          cnt_inc;
    logic signed [31:0]           sum_a;
    logic signed [31:0]           sum_b;
    logic signed [AXIS_TDATA_WIDTH-1:0] out_a;
    logic signed [AXIS_TDATA_WIDTH-1:0] out_b;
    logic                         unused_hi;

    // Only the low 16 bits of each input word carry the sample.
    assign unused_hi = ^{s0_axis_tdata[AXIS_TDATA_WIDTH-1:16], s1_axis_tdata[AXIS_TDATA_WIDTH-1:16]};

    // NOTE: every signal driven here gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_d  = cfg_en ? ST_RUN : ST_IDLE;
        cnt_d    = cnt_q;
        n_d      = n_q;
        acc_a_d  = acc_a_q;
        acc_b_d  = acc_b_q;
        res_a_d  = res_a_q;
        res_b_d  = res_b_q;
        tvalid_d = tvalid_q;
        ovr_d    = ovr_q;
        drop     = 1'b0;

        accept  = cfg_en & s0_axis_tvalid & s1_axis_tvalid;
        cnt_cur = (state_q == ST_RUN) ? cnt_q : '0;
        // N comes from cfg_data on the first sample of a block, else from the latched copy.
        n_cur   = (cnt_cur == '0) ? cfg_data : n_q;
        n_eff   = (n_cur == '0) ? {{(CNTR_WIDTH-1){1'b0}}, 1'b1} : n_cur;
        cnt_inc = {1'b0, cnt_cur} + {{CNTR_WIDTH{1'b0}}, 1'b1};
        last    = accept && (cnt_inc == {1'b0, n_eff});
        sum_a   = ((state_q == ST_RUN) ? acc_a_q : 32'sd0)
                  + {{16{s0_axis_tdata[15]}}, s0_axis_tdata[15:0]};
        sum_b   = ((state_q == ST_RUN) ? acc_b_q : 32'sd0)
                  + {{16{s1_axis_tdata[15]}}, s1_axis_tdata[15:0]};

        if (!cfg_en) begin
            cnt_d   = '0;
            acc_a_d = '0;
            acc_b_d = '0;
        end else if (accept) begin
            if (cnt_cur == '0) n_d = cfg_data;
            if (last) begin
                cnt_d   = '0;
                acc_a_d = '0;
                acc_b_d = '0;
            end else begin
                cnt_d   = cnt_inc[CNTR_WIDTH-1:0];
                acc_a_d = sum_a;
                acc_b_d = sum_b;
            end
        end

        // A completed block loads unless an untransferred result is still blocked.
        if (last) begin
            if (!tvalid_q || m_axis_tready) begin
                res_a_d  = sum_a;
                res_b_d  = sum_b;
                tvalid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
                drop  = 1'b1;
            end
        end else if (tvalid_q && m_axis_tready) begin
            tvalid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            n_q      <= '0;
            acc_a_q  <= '0;
            acc_b_q  <= '0;
            res_a_q  <= '0;
            res_b_q  <= '0;
            tvalid_q <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            n_q      <= n_d;
            acc_a_q  <= acc_a_d;
            acc_b_q  <= acc_b_d;
            res_a_q  <= res_a_d;
            res_b_q  <= res_b_d;
            tvalid_q <= tvalid_d;
            ovr_q    <= ovr_d;
        end
    end

`ifdef ADC_DECIM_OVR_COUNT_EN
    logic [15:0] ovr_cnt_q, ovr_cnt_d;

    always_comb begin
        ovr_cnt_d = ovr_cnt_q;
        if (drop && (ovr_cnt_q != 16'hFFFF)) ovr_cnt_d = ovr_cnt_q + 16'd1;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) ovr_cnt_q <= '0;
        else        ovr_cnt_q <= ovr_cnt_d;
    end

    assign sts_ovr_count = ovr_cnt_q;
`endif

    assign out_a         = res_a_q;
    assign out_b         = res_b_q;
    assign m_axis_tdata  = {out_b, out_a};
    assign m_axis_tvalid = tvalid_q;
    assign sts_overrun   = ovr_q;

endmodule
